if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS core.
//  - Owns the PC and drives the instruction-memory address.
//  - Selects the next PC from sequential, jump, bne and jr redirects.
//  - Registers instruction and PC+4 into ID; inserts a NOP bubble on if_flush
//    (from the instruction-discard logic) and holds on stall (from the hazard unit).
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  NOP_INSTR 32'h0000_0000  bubble instruction written to IF/ID on flush/reset
//  CNT_W     16             width of flush counter
// PORTS
//  clk           in   1      rising-edge clock
//  reset_n       in   1      asynchronous active-low reset
//  stall         in   1      hold PC and IF/ID (load-use hazard)
//  if_flush      in   1      squash the instruction being fetched this cycle
//  jump          in   1      j/jal resolved in ID this cycle
//  jump_target   in   32     target for jump
//  bne_taken     in   1      bne resolved taken in ID this cycle
//  branch_target in   32     target for bne
//  jr            in   1      jr resolved in ID this cycle
//  jr_target     in   32     register target for jr
//  imem_addr     out  32     instruction-memory address (= PC, combinational)
//  imem_rdata    in   32     instruction word for imem_addr, same cycle
//  id_instr      out  32     IF/ID instruction
//  id_pc_plus4   out  32     IF/ID PC+4
//  id_valid      out  1      1 = id_instr is a real fetched instruction
//  flush_cnt     out  CNT_W  number of bubbles inserted by if_flush
// BEHAVIOUR
//  Clock and reset: one clock (clk); reset_n asynchronous, active-low.
//  Reset values (async, while reset_n=0):
//   - PC=RESET_PC, id_instr=NOP_INSTR, id_pc_plus4=0, id_valid=0, flush_cnt=0.
//   - First fetch is from RESET_PC on the first rising edge after reset_n rises.
//  Next PC, highest priority first:
//   stall > jr > bne_taken > jump > PC+4.
//   - stall=1: PC and all IF/ID regs hold. Redirects and if_flush are ignored
//     that cycle; the hazard unit guarantees the ID branch re-resolves next cycle.
//   - Targets are loaded with bits [1:0] forced to 2'b00.
//   - PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
//  IF/ID update (each edge with stall=0):
//   - if_flush=1: id_instr=NOP_INSTR, id_valid=0, id_pc_plus4=PC+4,
//     flush_cnt += 1 (saturates at all-ones).
//   - otherwise: id_instr=imem_rdata, id_pc_plus4=PC+4, id_valid=1.
//  if_flush with no redirect: bubble inserted, PC still advances to PC+4.
//  Redirect with if_flush=0: PC redirects, fetched instruction is kept
//   (delay-slot semantics). Not produced by the discard logic, but legal.
//  Latency:
//   - Instruction fetched in cycle N appears on id_instr in cycle N+1.
//   - A redirect asserted in cycle N makes imem_addr = target in cycle N+1.
//  Reset mid-operation: all state returns to reset values immediately,
//   with no dependence on clk.
// TESTING
//  1 Reset release, no stall/flush, imem_rdata=PC -> id_instr 0,4,8,... one cycle behind; id_valid=1.
//  2 At PC=0x10, jump=1, jump_target=0x40, if_flush=1 -> next imem_addr=0x40; id_instr=NOP, id_valid=0, flush_cnt=1.
//  3 jr=1 (target 0x80), bne_taken=1 (target 0x20), jump=1 (target 0x40), all in one cycle -> PC=0x80.
//  4 stall=1 for 3 cycles with jump=1 -> PC and id_instr unchanged throughout; flush_cnt unchanged.
//  5 PC=0xFFFF_FFFC, no redirect -> PC=0; jr_target=0x103 -> PC=0x100.
//  6 Assert reset_n=0 mid-cycle after 5 fetches -> outputs at reset values before next edge; refetch from RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, picks the next PC from the ID-stage
// redirects, and holds the IF/ID pipeline register (bubble on flush, hold on stall).
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             stall,
   input  logic             if_flush,
   input  logic             jump,
   input  logic [31:0]      jump_target,
   input  logic             bne_taken,
   input  logic [31:0]      branch_target,
   input  logic             jr,
   input  logic [31:0]      jr_target,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      id_instr,
   output logic [31:0]      id_pc_plus4,
   output logic             id_valid,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [31:0]      WORD_MASK = 32'hFFFF_FFFC;
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      instr_q, instr_d;
   logic [31:0]      pc4_q, pc4_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] fcnt_q, fcnt_d;
   logic [31:0]      pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      fcnt_d  = fcnt_q;
      // A stalled cycle ignores redirects and flushes; ID re-resolves them next cycle.
      if (!stall) begin
         if (jr)             pc_d = jr_target & WORD_MASK;
         else if (bne_taken) pc_d = branch_target & WORD_MASK;
         else if (jump)      pc_d = jump_target & WORD_MASK;
         else                pc_d = pc_plus4;

         pc4_d = pc_plus4;
         if (if_flush) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            if (fcnt_q != {CNT_W{1'b1}}) fcnt_d = fcnt_q + CNT_ONE;
         end else begin
            instr_d = imem_rdata;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         pc4_q   <= 32'd0;
         valid_q <= 1'b0;
         fcnt_q  <= '0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign imem_addr   = pc_q;
   assign id_instr    = instr_q;
   assign id_pc_plus4 = pc4_q;
   assign id_valid    = valid_q;
   assign flush_cnt   = fcnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; instruction memory returns its own address.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        stall, if_flush, jump, bne_taken, jr;
   logic [31:0] jump_target, branch_target, jr_target;
   logic [31:0] imem_addr, imem_rdata, id_instr, id_pc_plus4;
   logic        id_valid;
   logic [2:0]  flush_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   if_fetch_stage #(.CNT_W(3)) dut (
      .clk(clk), .reset_n(reset_n), .stall(stall), .if_flush(if_flush),
      .jump(jump), .jump_target(jump_target), .bne_taken(bne_taken),
      .branch_target(branch_target), .jr(jr), .jr_target(jr_target),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata), .id_instr(id_instr),
      .id_pc_plus4(id_pc_plus4), .id_valid(id_valid), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;
   assign imem_rdata = imem_addr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic vld, input logic [2:0] cnt);
      chk({tag, ".addr"},  imem_addr, addr);
      chk({tag, ".instr"}, id_instr, instr);
      chk({tag, ".pc4"},   id_pc_plus4, pc4);
      chk({tag, ".valid"}, {31'd0, id_valid}, {31'd0, vld});
      chk({tag, ".fcnt"},  {29'd0, flush_cnt}, {29'd0, cnt});
   endtask

   task automatic clr();
      stall = 0; if_flush = 0; jump = 0; bne_taken = 0; jr = 0;
      jump_target = 0; branch_target = 0; jr_target = 0;
   endtask

   initial begin
      reset_n = 1'b0;
      clr();
      #12;
      chk_state("rst", 32'h0, 32'h0, 32'h0, 1'b0, 3'd0);
      @(negedge clk) reset_n = 1'b1;

      // 1: sequential fetch, one cycle behind
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk_state($sformatf("seq%0d", k), 32'(4*k), 32'(4*(k-1)), 32'(4*k), 1'b1, 3'd0);
      end

      // 2: jump with flush at PC=0x10
      jump = 1; jump_target = 32'h40; if_flush = 1;
      tick();
      chk_state("jflush", 32'h40, 32'h0, 32'h14, 1'b0, 3'd1);
      clr();
      tick();
      chk_state("postj", 32'h44, 32'h40, 32'h44, 1'b1, 3'd1);

      // 3: priority jr > bne > jump, delay-slot instruction kept
      jr = 1; jr_target = 32'h80; bne_taken = 1; branch_target = 32'h20;
      jump = 1; jump_target = 32'h40;
      tick();
      chk_state("prio_jr", 32'h80, 32'h44, 32'h48, 1'b1, 3'd1);
      jr = 0;
      tick();
      chk_state("prio_bne", 32'h20, 32'h80, 32'h84, 1'b1, 3'd1);
      clr();

      // 4: stall holds everything, ignoring jump and flush
      stall = 1; jump = 1; jump_target = 32'h40; if_flush = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_state($sformatf("stall%0d", k), 32'h20, 32'h80, 32'h84, 1'b1, 3'd1);
      end
      clr();
      tick();
      chk_state("unstall", 32'h24, 32'h20, 32'h24, 1'b1, 3'd1);

      // 5: target masking, PC wrap, jr target masking
      jump = 1; jump_target = 32'hFFFF_FFFF;
      tick();
      chk_state("jmask", 32'hFFFF_FFFC, 32'h24, 32'h28, 1'b1, 3'd1);
      clr();
      tick();
      chk_state("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 3'd1);
      jr = 1; jr_target = 32'h103;
      tick();
      chk_state("jrmask", 32'h100, 32'h0, 32'h4, 1'b1, 3'd1);
      clr();

      // flush without redirect: PC advances, counter saturates at all-ones
      if_flush = 1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk_state($sformatf("sat%0d", k), 32'(32'h100 + 4*k), 32'h0, 32'(32'h100 + 4*k), 1'b0,
                   (k + 1 > 7) ? 3'd7 : 3'(k + 1));
      end
      clr();

      // 6: asynchronous reset mid-cycle after 5 fetches
      tick();
      for (int k = 0; k < 4; k++) tick();
      chk("pre_rst.addr", imem_addr, 32'h134);
      #2 reset_n = 1'b0;
      #1;
      chk_state("arst", 32'h0, 32'h0, 32'h0, 1'b0, 3'd0);
      @(negedge clk) reset_n = 1'b1;
      tick();
      chk_state("refetch", 32'h4, 32'h0, 32'h4, 1'b1, 3'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
